// File: rtl/font_pkg.sv
// -----------------------------------------------------------------------------
// font_pkg
// Shared definitions for the glyph ROM arbiter:
//   - default glyph ROM address and data widths
//   - tag_e       : source of the ROM read issued in a cycle (none/video/CPU)
//   - cpu_state_e : CPU request FSM states
// -----------------------------------------------------------------------------
package font_pkg;

   localparam int FONT_ADDR_WIDTH = 11;
   localparam int FONT_DATA_WIDTH = 8;

   typedef enum logic [1:0] {
      TAG_NONE = 2'd0,
      TAG_VID  = 2'd1,
      TAG_CPU  = 2'd2
   } tag_e;

   typedef enum logic [1:0] {
      C_IDLE = 2'd0,
      C_WAIT = 2'd1,
      C_RESP = 2'd2
   } cpu_state_e;

endpackage

// File: rtl/font_rom_arbiter.sv
// -----------------------------------------------------------------------------
// font_rom_arbiter
// Shares one registered-output glyph ROM between a video pipeline (absolute
// priority, never stalled) and a CPU port (granted only in video-idle cycles).
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   vid_req, vid_addr      video read request / address
//   vid_valid, vid_data    video read result, one cycle after vid_req
//   cpu_req, cpu_addr      CPU read request (held until cpu_gnt) / address
//   cpu_gnt                CPU request accepted this cycle
//   cpu_rvalid, cpu_rdata  CPU read result pulse / last CPU read data
//   cpu_busy               CPU request pending or in flight
//   wait_max               longest CPU wait seen, saturating
//   rom_addr, rom_data     glyph ROM address out / data in (1-cycle latency)
// -----------------------------------------------------------------------------
module font_rom_arbiter
   import font_pkg::*;
#(
   parameter int ADDR_WIDTH = FONT_ADDR_WIDTH,
   parameter int DATA_WIDTH = FONT_DATA_WIDTH,
   parameter int WAIT_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  vid_req,
   input  logic [ADDR_WIDTH-1:0] vid_addr,
   output logic                  vid_valid,
   output logic [DATA_WIDTH-1:0] vid_data,
   input  logic                  cpu_req,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   output logic                  cpu_gnt,
   output logic                  cpu_rvalid,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  cpu_busy,
   output logic [WAIT_WIDTH-1:0] wait_max,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_data
);

   localparam logic [WAIT_WIDTH-1:0] WAIT_ONES = {WAIT_WIDTH{1'b1}};
   localparam logic [WAIT_WIDTH-1:0] WAIT_ZERO = {WAIT_WIDTH{1'b0}};
   localparam logic [WAIT_WIDTH-1:0] WAIT_ONE  = {{(WAIT_WIDTH-1){1'b0}}, 1'b1};

   // Requests are masked while in reset so nothing is granted or issued then.
   logic vid_s;
   logic cpu_req_s;
   logic cpu_issue_s;
   logic cpu_blocked_s;

   cpu_state_e            state_q,     state_d;
   tag_e                  tag_q,       tag_d;
   logic [ADDR_WIDTH-1:0] addr_hold_q, addr_hold_d;
   logic [DATA_WIDTH-1:0] rdata_q,     rdata_d;
   logic [WAIT_WIDTH-1:0] wait_cnt_q,  wait_cnt_d;
   logic [WAIT_WIDTH-1:0] wait_max_q,  wait_max_d;

   assign vid_s     = vid_req & reset_n;
   assign cpu_req_s = cpu_req & reset_n;

   // CPU FSM next state, grant and "request refused this cycle" decode.
   always_comb begin
      state_d       = state_q;
      cpu_issue_s   = 1'b0;
      cpu_blocked_s = 1'b0;
      case (state_q)
         C_IDLE: begin
            if (cpu_req_s && vid_s) begin
               cpu_blocked_s = 1'b1;
               state_d       = C_WAIT;
            end else if (cpu_req_s) begin
               cpu_issue_s = 1'b1;
               state_d     = C_RESP;
            end else begin
               state_d = C_IDLE;
            end
         end
         C_WAIT: begin
            // A dropped request while waiting is abandoned without a grant.
            if (!cpu_req_s) begin
               state_d = C_IDLE;
            end else if (vid_s) begin
               cpu_blocked_s = 1'b1;
               state_d       = C_WAIT;
            end else begin
               cpu_issue_s = 1'b1;
               state_d     = C_RESP;
            end
         end
         C_RESP: begin
            // Never grant here: back-to-back CPU reads are at least 2 cycles apart.
            state_d = C_IDLE;
         end
         default: begin
            state_d = C_IDLE;
         end
      endcase
   end

   // ROM address mux, issue tag and held address.
   always_comb begin
      rom_addr = addr_hold_q;
      tag_d    = TAG_NONE;
      if (vid_s) begin
         rom_addr = vid_addr;
         tag_d    = TAG_VID;
      end else if (cpu_issue_s) begin
         rom_addr = cpu_addr;
         tag_d    = TAG_CPU;
      end else begin
         rom_addr = addr_hold_q;
         tag_d    = TAG_NONE;
      end
      addr_hold_d = rom_addr;
   end

   // Wait counter counts every cycle a CPU request is refused (including the
   // first refusal in C_IDLE); it is folded into wait_max at grant.
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      wait_max_d = wait_max_q;
      if (cpu_issue_s) begin
         wait_cnt_d = WAIT_ZERO;
         if (wait_cnt_q > wait_max_q) begin
            wait_max_d = wait_cnt_q;
         end else begin
            wait_max_d = wait_max_q;
         end
      end else if (cpu_blocked_s) begin
         if (wait_cnt_q == WAIT_ONES) begin
            wait_cnt_d = wait_cnt_q;
         end else begin
            wait_cnt_d = wait_cnt_q + WAIT_ONE;
         end
      end else begin
         wait_cnt_d = WAIT_ZERO;
      end
   end

   // CPU read data: bypass ROM data in the response cycle, hold otherwise.
   always_comb begin
      if (tag_q == TAG_CPU) begin
         rdata_d = rom_data;
      end else begin
         rdata_d = rdata_q;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= C_IDLE;
         tag_q       <= TAG_NONE;
         addr_hold_q <= {ADDR_WIDTH{1'b0}};
         rdata_q     <= {DATA_WIDTH{1'b0}};
         wait_cnt_q  <= WAIT_ZERO;
         wait_max_q  <= WAIT_ZERO;
      end else begin
         state_q     <= state_d;
         tag_q       <= tag_d;
         addr_hold_q <= addr_hold_d;
         rdata_q     <= rdata_d;
         wait_cnt_q  <= wait_cnt_d;
         wait_max_q  <= wait_max_d;
      end
   end

   assign vid_valid  = (tag_q == TAG_VID);
   assign vid_data   = (tag_q == TAG_VID) ? rom_data : {DATA_WIDTH{1'b0}};
   assign cpu_gnt    = cpu_issue_s;
   assign cpu_rvalid = (state_q == C_RESP);
   assign cpu_rdata  = rdata_d;
   assign cpu_busy   = (state_q != C_IDLE) | cpu_req_s;
   assign wait_max   = wait_max_q;

endmodule

// File: tb/tb_font_rom_arbiter.sv
// -----------------------------------------------------------------------------
// tb_font_rom_arbiter
// Directed bench for font_rom_arbiter: a per-cycle vector table plus
// hand-written sequences for mid-transaction reset and counter saturation.
// A second instance with a 4-bit wait counter exercises saturation cheaply.
// -----------------------------------------------------------------------------
module tb_font_rom_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        vid_req, cpu_req;
   logic [10:0] vid_addr, cpu_addr;
   logic        vid_valid, cpu_gnt, cpu_rvalid, cpu_busy;
   logic [7:0]  vid_data, cpu_rdata;
   logic [15:0] wait_max;
   logic [10:0] rom_addr;
   logic [7:0]  rom_data;

   logic        s_vid_req, s_cpu_req;
   logic [10:0] s_vid_addr, s_cpu_addr;
   logic        s_vid_valid, s_cpu_gnt, s_cpu_rvalid, s_cpu_busy;
   logic [7:0]  s_vid_data, s_cpu_rdata;
   logic [3:0]  s_wait_max;
   logic [10:0] s_rom_addr;
   logic [7:0]  s_rom_data;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   function automatic logic [7:0] rom_f(input logic [10:0] a);
      return a[7:0] ^ {a[10:8], 5'b10110};
   endfunction

   // Glyph ROM models: registered output, one-cycle latency.
   always_ff @(posedge clk) rom_data   <= rom_f(rom_addr);
   always_ff @(posedge clk) s_rom_data <= rom_f(s_rom_addr);

   font_rom_arbiter dut (
      .clk(clk), .reset_n(reset_n),
      .vid_req(vid_req), .vid_addr(vid_addr),
      .vid_valid(vid_valid), .vid_data(vid_data),
      .cpu_req(cpu_req), .cpu_addr(cpu_addr),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .cpu_busy(cpu_busy), .wait_max(wait_max),
      .rom_addr(rom_addr), .rom_data(rom_data)
   );

   font_rom_arbiter #(.WAIT_WIDTH(4)) u_sat (
      .clk(clk), .reset_n(reset_n),
      .vid_req(s_vid_req), .vid_addr(s_vid_addr),
      .vid_valid(s_vid_valid), .vid_data(s_vid_data),
      .cpu_req(s_cpu_req), .cpu_addr(s_cpu_addr),
      .cpu_gnt(s_cpu_gnt), .cpu_rvalid(s_cpu_rvalid), .cpu_rdata(s_cpu_rdata),
      .cpu_busy(s_cpu_busy), .wait_max(s_wait_max),
      .rom_addr(s_rom_addr), .rom_data(s_rom_data)
   );

   typedef struct {
      logic        vr;
      logic [10:0] va;
      logic        cr;
      logic [10:0] ca;
      logic [46:0] exp;   // {vv, vd, gnt, rv, busy, rom_addr, rdata, wait_max}
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic vr, input logic [10:0] va, input logic cr, input logic [10:0] ca,
                      input logic vv, input logic [10:0] vda, input logic gnt, input logic rv,
                      input logic busy, input logic [10:0] raddr, input logic [7:0] rdata,
                      input logic [15:0] wmax);
      vec_t v;
      logic [7:0] vd;
      vd    = vv ? rom_f(vda) : 8'h00;
      v.vr  = vr;
      v.va  = va;
      v.cr  = cr;
      v.ca  = ca;
      v.exp = {vv, vd, gnt, rv, busy, raddr, rdata, wmax};
      vecs.push_back(v);
   endtask

   function automatic logic [46:0] outs();
      return {vid_valid, vid_data, cpu_gnt, cpu_rvalid, cpu_busy, rom_addr, cpu_rdata, wait_max};
   endfunction

   initial begin
      logic [7:0] r41, r55, r60, r61, r62, r63, r71;
      r41 = rom_f(11'h041); r55 = rom_f(11'h055);
      r60 = rom_f(11'h060); r61 = rom_f(11'h061);
      r62 = rom_f(11'h062); r63 = rom_f(11'h063);
      r71 = rom_f(11'h071);

      // V1: 8-cycle video burst, valids one cycle later, no gaps.
      for (int i = 0; i < 8; i++)
         add(1'b1, 11'h100 + 11'(i), 1'b0, 11'h000, (i > 0), 11'h100 + 11'(i) - 11'h001,
             1'b0, 1'b0, 1'b0, 11'h100 + 11'(i), 8'h00, 16'h0000);
      add(1'b0, 11'h000, 1'b0, 11'h000, 1'b1, 11'h107, 1'b0, 1'b0, 1'b0, 11'h107, 8'h00, 16'h0000);
      add(1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 1'b0, 1'b0, 11'h107, 8'h00, 16'h0000);
      // V2: CPU read with video idle.
      add(1'b0, 11'h000, 1'b1, 11'h041, 1'b0, 11'h000, 1'b1, 1'b0, 1'b1, 11'h041, 8'h00, 16'h0000);
      add(1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 1'b1, 1'b1, 11'h041, r41,   16'h0000);
      add(1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 1'b0, 1'b0, 11'h041, r41,   16'h0000);
      // V3: CPU request during a 5-cycle video burst.
      for (int i = 0; i < 5; i++)
         add(1'b1, 11'h200 + 11'(i), 1'b1, 11'h055, (i > 0), 11'h200 + 11'(i) - 11'h001,
             1'b0, 1'b0, 1'b1, 11'h200 + 11'(i), r41, 16'h0000);
      add(1'b0, 11'h000, 1'b1, 11'h055, 1'b1, 11'h204, 1'b1, 1'b0, 1'b1, 11'h055, r41, 16'h0000);
      add(1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 1'b1, 1'b1, 11'h055, r55, 16'h0005);
      add(1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 1'b0, 1'b0, 11'h055, r55, 16'h0005);
      // V4: alternating video, 4 CPU reads granted only in video-off cycles.
      add(1'b1, 11'h300, 1'b1, 11'h060, 1'b0, 11'h000, 1'b0, 1'b0, 1'b1, 11'h300, r55, 16'h0005);
      add(1'b0, 11'h000, 1'b1, 11'h060, 1'b1, 11'h300, 1'b1, 1'b0, 1'b1, 11'h060, r55, 16'h0005);
      add(1'b1, 11'h301, 1'b1, 11'h061, 1'b0, 11'h000, 1'b0, 1'b1, 1'b1, 11'h301, r60, 16'h0005);
      add(1'b0, 11'h000, 1'b1, 11'h061, 1'b1, 11'h301, 1'b1, 1'b0, 1'b1, 11'h061, r60, 16'h0005);
      add(1'b1, 11'h302, 1'b1, 11'h062, 1'b0, 11'h000, 1'b0, 1'b1, 1'b1, 11'h302, r61, 16'h0005);
      add(1'b0, 11'h000, 1'b1, 11'h062, 1'b1, 11'h302, 1'b1, 1'b0, 1'b1, 11'h062, r61, 16'h0005);
      add(1'b1, 11'h303, 1'b1, 11'h063, 1'b0, 11'h000, 1'b0, 1'b1, 1'b1, 11'h303, r62, 16'h0005);
      add(1'b0, 11'h000, 1'b1, 11'h063, 1'b1, 11'h303, 1'b1, 1'b0, 1'b1, 11'h063, r62, 16'h0005);
      add(1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 1'b1, 1'b1, 11'h063, r63, 16'h0005);
      add(1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 1'b0, 1'b0, 11'h063, r63, 16'h0005);
      // Abandoned wait of 7 cycles: no grant, wait_max unchanged, later read clean.
      for (int i = 0; i < 7; i++)
         add(1'b1, 11'h3A0 + 11'(i), 1'b1, 11'h070, (i > 0), 11'h3A0 + 11'(i) - 11'h001,
             1'b0, 1'b0, 1'b1, 11'h3A0 + 11'(i), r63, 16'h0005);
      add(1'b0, 11'h000, 1'b0, 11'h000, 1'b1, 11'h3A6, 1'b0, 1'b0, 1'b1, 11'h3A6, r63, 16'h0005);
      add(1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 1'b0, 1'b0, 11'h3A6, r63, 16'h0005);
      add(1'b0, 11'h000, 1'b1, 11'h071, 1'b0, 11'h000, 1'b1, 1'b0, 1'b1, 11'h071, r63, 16'h0005);
      add(1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 1'b1, 1'b1, 11'h071, r71, 16'h0005);
      add(1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 1'b0, 1'b0, 11'h071, r71, 16'h0005);

      // Reset state, with requests driven to show they are masked.
      reset_n    = 1'b0;
      vid_req    = 1'b1; vid_addr = 11'h155;
      cpu_req    = 1'b1; cpu_addr = 11'h0AA;
      s_vid_req  = 1'b0; s_vid_addr = 11'h000;
      s_cpu_req  = 1'b0; s_cpu_addr = 11'h000;
      repeat (3) @(negedge clk);
      #2;
      check("reset_outputs", 64'(outs()), 64'(47'h0));
      check("reset_sat_wait_max", 64'(s_wait_max), 64'h0);
      vid_req = 1'b0; cpu_req = 1'b0;

      // Release at a negedge; first vector is taken by the very next clock.
      @(negedge clk);
      reset_n = 1'b1;
      for (int k = 0; k < vecs.size(); k++) begin
         vid_req  = vecs[k].vr;
         vid_addr = vecs[k].va;
         cpu_req  = vecs[k].cr;
         cpu_addr = vecs[k].ca;
         #2;
         check($sformatf("vec%0d", k), 64'(outs()), 64'(vecs[k].exp));
         @(negedge clk);
      end

      // V6: reset pulsed while the CPU read is in C_RESP.
      vid_req = 1'b0; vid_addr = 11'h000;
      cpu_req = 1'b1; cpu_addr = 11'h0AA;
      #2;
      check("v6_gnt", 64'(cpu_gnt), 64'h1);
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      check("v6_reset_outputs", 64'(outs()), 64'(47'h0));
      @(posedge clk);
      #1;
      check("v6_no_rvalid", 64'({cpu_rvalid, vid_valid, cpu_gnt, cpu_busy}), 64'h0);
      @(negedge clk);
      reset_n  = 1'b1;
      cpu_addr = 11'h0AB;
      #2;
      check("v6_fresh_gnt", 64'({cpu_gnt, rom_addr}), 64'({1'b1, 11'h0AB}));
      @(negedge clk);
      cpu_req = 1'b0;
      #2;
      check("v6_fresh_read", 64'({cpu_rvalid, cpu_rdata}), 64'({1'b1, rom_f(11'h0AB)}));
      @(negedge clk);

      // V5: saturation on the 4-bit instance. 14 refused cycles -> 0xE.
      s_vid_req = 1'b1; s_vid_addr = 11'h010;
      s_cpu_req = 1'b1; s_cpu_addr = 11'h011;
      repeat (14) @(negedge clk);
      s_vid_req = 1'b0;
      #2;
      check("v5_gnt1", 64'(s_cpu_gnt), 64'h1);
      @(negedge clk);
      s_cpu_req = 1'b0;
      #2;
      check("v5_wait_max_e", 64'({s_cpu_rvalid, s_wait_max}), 64'({1'b1, 4'hE}));
      @(negedge clk);
      // 17 refused cycles: counter must stick at all-ones, not wrap.
      s_vid_req = 1'b1;
      s_cpu_req = 1'b1; s_cpu_addr = 11'h012;
      repeat (17) @(negedge clk);
      s_vid_req = 1'b0;
      #2;
      check("v5_gnt2", 64'(s_cpu_gnt), 64'h1);
      @(negedge clk);
      s_cpu_req = 1'b0;
      #2;
      check("v5_wait_max_f", 64'(s_wait_max), 64'hF);
      check("v5_rdata", 64'({s_cpu_rvalid, s_cpu_rdata}), 64'({1'b1, rom_f(11'h012)}));
      @(negedge clk);
      #2;
      check("v5_hold", 64'({s_cpu_busy, s_wait_max}), 64'({1'b0, 4'hF}));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
